// File: rtl/tt_mar_pkg.sv
// Shared constants, pin-field positions and types for the MAR register-file tile.
// Optional macro TT_MAR_WR_BYPASS_EN is consumed by mar_regfile.
package tt_mar_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned NREGS  = 4;
    localparam int unsigned ADDR_W = $clog2(NREGS);

    // ui_in fields
    localparam int unsigned D_LSB    = 0;
    localparam int unsigned WSEL_LSB = 4;
    localparam int unsigned RSEL_LSB = 6;

    // uio_in fields
    localparam int unsigned G_BIT   = 0;
    localparam int unsigned G1N_BIT = 1;
    localparam int unsigned OE_BIT  = 2;
    localparam int unsigned G2N_BIT = 3;

    // uo_out fields
    localparam int unsigned RDATA_LSB = 0;
    localparam int unsigned MAR_LSB   = 4;
    localparam int unsigned WRACK_BIT = 6;
    localparam int unsigned PAR_BIT   = 7;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    function automatic logic even_par(input data_t d);
        return ^d;
    endfunction

endpackage

// File: rtl/mar_regfile.sv
// 4x4 register file in the style of a 74x170: independent write/read addresses,
// registered storage, combinational gated read. Bypass under TT_MAR_WR_BYPASS_EN.
module mar_regfile
    import tt_mar_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  addr_t waddr,
    input  data_t wdata,
    input  addr_t raddr,
    input  logic  oe,
    output data_t rdata
);

    data_t regs_q [NREGS];
    data_t regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (oe) begin
`ifdef TT_MAR_WR_BYPASS_EN
            // Write-through: a same-address read sees the incoming data this cycle.
            if (we && (raddr == waddr)) begin
                rdata = wdata;
            end else begin
                rdata = regs_q[raddr];
            end
`else
            rdata = regs_q[raddr];
`endif
        end
    end

endmodule

// File: rtl/tt_um_trinhgiahuy.sv
// Tiny Tapeout tile: 4x4 register file plus memory address register and write pulse.
// Optional write-through read bypass: define TT_MAR_WR_BYPASS_EN.
module tt_um_trinhgiahuy
    import tt_mar_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // rst_n is active-high despite its name; kept for pin compatibility.
    logic  rst;
    data_t d_in;
    addr_t wsel;
    addr_t rsel;
    logic  we;
    logic  oe;
    data_t rdata;

    addr_t mar_q, mar_d;
    logic  wr_ack_q, wr_ack_d;

    logic  unused_bits;

    assign rst  = rst_n;
    assign d_in = ui_in[D_LSB +: DATA_W];
    assign wsel = ui_in[WSEL_LSB +: ADDR_W];
    assign rsel = ui_in[RSEL_LSB +: ADDR_W];
    assign oe   = uio_in[OE_BIT];
    assign we   = ena & uio_in[G_BIT] & ~uio_in[G1N_BIT] & ~uio_in[G2N_BIT];

    assign unused_bits = &{1'b0, uio_in[7:4]};

    mar_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wsel),
        .wdata (d_in),
        .raddr (rsel),
        .oe    (oe),
        .rdata (rdata)
    );

    always_comb begin
        mar_d    = mar_q;
        wr_ack_d = 1'b0;
        if (we) begin
            mar_d    = wsel;
            wr_ack_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mar_q    <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            mar_q    <= mar_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    always_comb begin
        uo_out                         = '0;
        uo_out[RDATA_LSB +: DATA_W]    = rdata;
        uo_out[MAR_LSB +: ADDR_W]      = mar_q;
        uo_out[WRACK_BIT]              = wr_ack_q;
        uo_out[PAR_BIT]                = even_par(rdata);
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_trinhgiahuy.sv
// Self-checking bench for tt_um_trinhgiahuy: directed plan steps plus random traffic
// against a behavioural model of the register file, MAR and write pulse.
module tb_tt_um_trinhgiahuy;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int  m_regs [4];
    int  m_mar;
    int  m_ack;
    bit  model_valid = 1'b0;

    tt_um_trinhgiahuy dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_we(input logic [7:0] ui, input logic [7:0] uio, input bit en);
        return en && uio[0] && !uio[1] && !uio[3];
    endfunction

    function automatic logic [7:0] model_out(input logic [7:0] ui, input logic [7:0] uio, input bit en);
        int d, wsel, rsel, rd, par;
        d    = ui % 16;
        wsel = (ui / 16) % 4;
        rsel = ui / 64;
        rd   = 0;
        if (uio[2]) begin
            rd = m_regs[rsel];
`ifdef TT_MAR_WR_BYPASS_EN
            if (model_we(ui, uio, en) && rsel == wsel) rd = d;
`endif
        end
        par = 0;
        for (int b = 0; b < 4; b++) par = par + ((rd >> b) & 1);
        return 8'((par % 2) * 128 + m_ack * 64 + m_mar * 16 + rd);
    endfunction

    // One clock: apply inputs, check combinational view before the edge, advance model.
    task automatic step(input string tag, input logic [7:0] ui, input logic [7:0] uio,
                        input bit en, input bit rs, input bit use_lit, input logic [7:0] lit);
        logic [7:0] exp;
        ui_in  = ui;
        uio_in = uio;
        ena    = en;
        rst_n  = rs;
        #1;
        if (model_valid) begin
            exp = model_out(ui, uio, en);
            checks++;
            assert (uo_out === exp) else begin
                errors++;
                $error("FAIL %s model: uo_out=%02h expected=%02h", tag, uo_out, exp);
            end
            checks++;
            assert ({uio_out, uio_oe} === 16'h0000) else begin
                errors++;
                $error("FAIL %s uio: uio_out=%02h uio_oe=%02h expected=00", tag, uio_out, uio_oe);
            end
        end
        if (use_lit) begin
            checks++;
            assert (uo_out === lit) else begin
                errors++;
                $error("FAIL %s literal: uo_out=%02h expected=%02h", tag, uo_out, lit);
            end
        end
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            m_mar = 0;
            m_ack = 0;
            model_valid = 1'b1;
        end else if (model_we(ui, uio, en)) begin
            m_regs[(ui / 16) % 4] = ui % 16;
            m_mar = (ui / 16) % 4;
            m_ack = 1;
        end else begin
            m_ack = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        ui_in  = '0;
        uio_in = '0;
        ena    = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);

        // reset with writes requested
        step("rst0", 8'($urandom), 8'h05, 1'b1, 1'b1, 1'b0, 8'h00);
        step("rst1", 8'($urandom), 8'h05, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int r = 0; r < 4; r++) begin
            step("rst_sweep", 8'(r * 64), 8'h04, 1'b1, 1'b0, 1'b1, 8'h00);
        end

        // basic write
        step("wr0", 8'h0A, 8'h05, 1'b1, 1'b0, 1'b0, 8'h00);
        step("wr0_rd", 8'h0A, 8'h04, 1'b1, 1'b0, 1'b1, 8'h4A);
        step("wr0_ack_low", 8'h0A, 8'h04, 1'b1, 1'b0, 1'b1, 8'h0A);

        // second address
        step("wr2", 8'h2F, 8'h05, 1'b1, 1'b0, 1'b1, 8'h0A);
        step("wr2_reg0", 8'h2F, 8'h04, 1'b1, 1'b0, 1'b1, 8'h6A);
        step("wr2_rd2", 8'hAF, 8'h04, 1'b1, 1'b0, 1'b1, 8'h2F);

        // gating: g1_n, g2_n, ena
        step("gate_g1n", 8'h83, 8'h07, 1'b1, 1'b0, 1'b1, 8'h2F);
        step("gate_g2n", 8'h83, 8'h0D, 1'b1, 1'b0, 1'b1, 8'h2F);
        step("gate_ena", 8'h83, 8'h05, 1'b0, 1'b0, 1'b1, 8'h2F);
        step("gate_reg0", 8'h03, 8'h04, 1'b1, 1'b0, 1'b1, 8'h2A);

        // oe low hides data but not MAR / wr_ack
        step("oe_off", 8'h13, 8'h01, 1'b1, 1'b0, 1'b1, 8'h20);
        step("oe_off_ack", 8'h13, 8'h01, 1'b1, 1'b0, 1'b1, 8'h50);
        step("oe_on_rd1", 8'h53, 8'h04, 1'b1, 1'b0, 1'b1, 8'h53);

        // read-during-write on address 1
        step("rdw_set5", 8'h55, 8'h05, 1'b1, 1'b0, 1'b0, 8'h00);
`ifdef TT_MAR_WR_BYPASS_EN
        step("rdw_same", 8'h56, 8'h05, 1'b1, 1'b0, 1'b1, 8'h56);
`else
        step("rdw_same", 8'h56, 8'h05, 1'b1, 1'b0, 1'b1, 8'h55);
`endif
        step("rdw_next", 8'h56, 8'h04, 1'b1, 1'b0, 1'b1, 8'h56);

        // reset mid-sequence
        step("rst_mid", 8'($urandom), 8'h05, 1'b1, 1'b1, 1'b0, 8'h00);
        step("rst_mid_rd", 8'h40, 8'h04, 1'b1, 1'b0, 1'b1, 8'h00);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            step("rand", 8'($urandom), {4'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                                        1'($urandom_range(0, 3) == 0), 1'($urandom)},
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0), 1'b0, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_trinhgiahuy.md
Name: tt_um_trinhgiahuy

Overview:
- Tiny Tapeout user tile implementing a 4-entry x 4-bit register file with a memory address register (MAR).
- The register file behaves like a 74x170: separate write and read addresses, a gated write strobe, and a read output enable.
- The MAR captures the address of the last committed write, and a status pulse flags each write.
- Sits directly on the standard tt_um pin interface; it has no sub-tile neighbours.

Parameters:
- DATA_W, 4, register width; fixed by the pin mapping, do not override.
- NREGS, 4, number of registers; the address width is log2(NREGS) = 2, fixed by the pin mapping.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset: synchronous and active-high. Asserted when 1 and sampled on the clk rising edge, despite the _n suffix.
- ena  in  1  tile enable; writes are ignored when 0.
- ui_in  in  8  [3:0] d_in write data; [5:4] wsel write address; [7:6] rsel read address.
- uio_in  in  8  [0] g write strobe (active-high); [1] g1_n write gate (active-low); [2] oe read output enable (active-high); [3] g2_n write gate (active-low); [7:4] unused.
- uo_out  out  8  [3:0] read data; [5:4] MAR; [6] wr_ack; [7] rd_par.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all uio pins are inputs).

Behaviour:
- Reset, when rst_n=1 at a clk edge:
  - all 4 registers cleared to 0.
  - MAR cleared to 0 and wr_ack cleared to 0.
  - Reset has priority over a simultaneous write.
- Write enable: we = ena & g & ~g1_n & ~g2_n.
  - When we=1 at a clk edge: reg[wsel] <= d_in, MAR <= wsel, and wr_ack <= 1.
  - Otherwise wr_ack <= 0 and the registers and MAR hold their values.
  - wr_ack is therefore a one-cycle pulse per write; back-to-back writes hold it high.
- Read port is combinational from registered state.
  - rdata = oe ? reg[rsel] : 4'h0.
  - uo_out[3:0] = rdata.
  - uo_out[7] = ^rdata, i.e. even-parity bit, 0 when oe=0.
- Read-during-write to the same address returns the old value in that cycle and the new value after the edge. The optional bypass feature changes this.
- uo_out[5:4] = MAR and uo_out[6] = wr_ack, both registered; neither is gated by oe.
- Boundary cases:
  - Any gate (g1_n or g2_n) high blocks writes regardless of g.
  - ena=0 blocks writes but reads still work.
  - Addresses are 2 bits, so every address is valid and there is no wrap logic.
  - Reset asserted mid-sequence clears all state on the next edge.
- Latency: write to readable data takes 1 clock; address change to read data takes 0 clocks (combinational).

Optional Feature:
- Macro: TT_MAR_WR_BYPASS_EN.
- When defined: if we=1 and rsel==wsel, rdata = oe ? d_in : 0 in the same cycle (write-through bypass); parity follows the bypassed value.
- When undefined: old-value read-during-write, as described under Behaviour.
- The registered state is identical in both builds.

Decomposition:
- Package tt_mar_pkg holds:
  - DATA_W and ADDR_W constants.
  - Bit-position localparams for ui_in, uio_in and uo_out fields (D_LSB, WSEL_LSB, RSEL_LSB, G_BIT, G1N_BIT, OE_BIT, G2N_BIT, WRACK_BIT, PAR_BIT).
- One sub-module, mar_regfile: 4x4 storage, write-enable decode, read mux and the optional bypass.
- The top level holds pin unpacking, MAR, wr_ack, parity and the constant uio outputs.

Test Plan:
- Reset: drive rst_n=1 for 2 clocks with random writes requested, then set rst_n=0, oe=1 and sweep rsel 0..3 -> uo_out=0x00 for every rsel.
- Basic write: ui_in=0x0A (d=0xA, wsel=0, rsel=0), uio_in=0x05 for 1 clock -> next cycle uo_out[3:0]=0xA, MAR=0, wr_ack=1, rd_par=0; one clock later wr_ack=0.
- Second address: ui_in=0x2F (d=0xF, wsel=2, rsel=0) with uio_in=0x05 -> reg2=0xF, MAR=2, reg0 still reads 0xA; set rsel=2 (ui_in=0xAF) -> uo_out[3:0]=0xF, rd_par=0.
- Gating: uio_in=0x07 (g1_n=1) or 0x0D (g2_n=1) or ena=0 with d=0x3 -> no register change, MAR unchanged, wr_ack=0.
- Output enable: uio_in=0x01 (oe=0) -> uo_out[3:0]=0, rd_par=0, while MAR and wr_ack remain visible.
- Read-during-write: rsel=wsel=1, reg1=0x5, write d=0x6 -> same cycle reads 0x5 (0x6 if TT_MAR_WR_BYPASS_EN), next cycle reads 0x6 with rd_par=0.
